sram_arbiter: RTL
=================

Name: sram_arbiter

Overview:
- Time-shares one single-port synchronous SRAM (1-cycle registered read) among three requesters: video scan-out (read-only), CPU (read/write) and DMA (read/write).
- Sits between the requesters and the sram instance, and issues at most one access per clock.
- Video has fixed priority. CPU and DMA alternate round-robin.
- A starvation guard stops video from locking out CPU/DMA indefinitely.

Parameters:
- ADDR_WIDTH, 16, SRAM address width.
- DATA_WIDTH, 8, SRAM data width.
- MAX_WAIT, 8, wait cycles after which a CPU/DMA request overrides video; range 1..255.
- STAT_WIDTH, 16, width of statistics counters (optional feature only).

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high reset.
- vid_req  in  1  video request; hold with vid_addr until granted.
- vid_addr  in  ADDR_WIDTH  video read address.
- vid_gnt  out  1  combinational; request accepted this cycle.
- vid_rvalid  out  1  registered; read data valid on rdata.
- cpu_req, cpu_addr, cpu_we, cpu_wdata  in  1/ADDR_WIDTH/1/DATA_WIDTH  CPU request; hold stable until granted.
- cpu_gnt  out  1  CPU accepted.
- cpu_rvalid  out  1  CPU read data valid.
- dma_req, dma_addr, dma_we, dma_wdata  in  1/ADDR_WIDTH/1/DATA_WIDTH  DMA request; hold stable until granted.
- dma_gnt  out  1  DMA accepted.
- dma_rvalid  out  1  DMA read data valid.
- rdata  out  DATA_WIDTH  shared registered read data; qualified by the *_rvalid strobes.
- sram_addr  out  ADDR_WIDTH  registered SRAM address.
- sram_data_in  out  DATA_WIDTH  registered SRAM write data.
- sram_write_enable  out  1  registered SRAM write strobe.
- sram_data_out  in  DATA_WIDTH  SRAM read data, valid one cycle after the address.

Behaviour:
- Reset (asynchronous) values:
  - all *_gnt, *_rvalid and sram_write_enable: 0
  - sram_addr, sram_data_in, rdata: 0
  - wait counters: 0
  - round-robin pointer: "DMA last", so CPU wins the first tie
  - in-flight tag pipeline: empty
- Handshake:
  - A transfer occurs on a posedge where req and gnt are both 1.
  - gnt is a combinational function of this cycle's reqs and the arbiter state.
  - At most one gnt is high per cycle.
  - gnt is never high while the matching req is low.
- Arbitration order, evaluated each cycle:
  1. A starving requester (wait counter == MAX_WAIT) with req high. If CPU and DMA are both starving, the round-robin pointer decides.
  2. vid_req.
  3. CPU/DMA round-robin: the one not granted last wins a tie; a lone requester always wins.
- Round-robin pointer: updates only on a CPU or DMA grant.
- Wait counters (CPU, DMA):
  - Increment, saturating at MAX_WAIT, each cycle the req is high and not granted.
  - Clear on grant, or when req is low.
- Pipeline for a grant in cycle N:
  - Posedge ending N: sram_addr, sram_data_in and the tag {source, is_read} register; sram_write_enable = we.
  - Cycle N+1: SRAM sees the access. A write completes here. sram_write_enable is 1 only in N+1 unless a new write is granted in N+1.
  - Cycle N+2: sram_data_out valid. The arbiter registers rdata at the posedge ending N+2.
  - Cycle N+3: rdata and exactly one *_rvalid are high, for the granted source, reads only.
  - Read latency is 3 cycles from the gnt cycle. Writes produce no rvalid.
- Throughput: back-to-back grants every cycle are allowed. The pipeline holds up to 3 tags in flight. Read data returns in grant order.
- Idle cycles: sram_addr holds its last value; sram_write_enable is 0.
- Read-after-write to the same address granted on consecutive cycles returns the newly written data, because the SRAM writes before the next read.
- Reset asserted mid-operation: in-flight tags are discarded, no rvalid follows, and sram_write_enable drops immediately.
- A requester that deasserts req before its grant has no access performed. Its counter clears.

Optional Feature:
- SRAM_ARB_STATS_EN defined:
  - Adds outputs stat_vid_grants, stat_cpu_grants, stat_dma_grants and stat_conflicts, each STAT_WIDTH wide.
  - Grant counters count grants per source; stat_conflicts counts cycles with two or more reqs high.
  - All four counters saturate at all-ones and reset to 0.
  - Adds input stat_clear, a synchronous zero of all four counters; a same-cycle event is not counted.
- SRAM_ARB_STATS_EN undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Single CPU read: cpu_req with cpu_addr=0x1234, cpu_we=0, after writing 0x5A there → cpu_gnt in cycle N, cpu_rvalid=1 and rdata=0x5A in N+3, no other rvalid.
- Video priority: vid_req and cpu_req held in the same cycle, MAX_WAIT=8 → vid_gnt every cycle for 8 cycles; cycle 9 cpu_gnt, counter clears; then video resumes.
- Round robin: cpu_req and dma_req held continuously, no video → grants alternate CPU, DMA, CPU, DMA starting with CPU after reset.
- Pipelined mix: grant CPU write 0x77→0x0010, then DMA read 0x0010, then video read 0x0020 on consecutive cycles → sram_write_enable high exactly one cycle; dma_rvalid with rdata=0x77, then vid_rvalid next cycle.
- Reset mid-flight: assert reset one cycle after a CPU read grant → sram_write_enable and all rvalid are 0 immediately, and no rvalid appears after reset is released.
- Stats (SRAM_ARB_STATS_EN): 5 CPU grants with 3 conflict cycles → stat_cpu_grants=5, stat_conflicts=3; a stat_clear pulse zeroes all four counters.

Source files
------------

// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Shares one single-port synchronous SRAM (1-cycle registered read) between
//   video scan-out (read-only), CPU (read/write) and DMA (read/write).
//   At most one access is issued per clock.
//   Arbitration order: a starving CPU/DMA first, then video, then CPU/DMA
//   round-robin. Read data returns 3 cycles after the grant, in grant order,
//   on the shared rdata bus qualified by one *_rvalid strobe.
//
// Ports
//   clk, reset                      clock, asynchronous active-high reset
//   vid_req/vid_addr -> vid_gnt     video read request, combinational grant
//   cpu_req/addr/we/wdata -> cpu_gnt   CPU request, combinational grant
//   dma_req/addr/we/wdata -> dma_gnt   DMA request, combinational grant
//   vid/cpu/dma_rvalid, rdata       registered read return
//   sram_addr, sram_data_in, sram_write_enable   registered SRAM controls
//   sram_data_out                   SRAM read data (one cycle after address)
//
// Optional feature: define SRAM_ARB_STATS_EN to add stat_clear and the
//   saturating counters stat_vid_grants, stat_cpu_grants, stat_dma_grants
//   and stat_conflicts (STAT_WIDTH bits each).
module sram_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_WAIT   = 8,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vid_req,
    input  logic [ADDR_WIDTH-1:0] vid_addr,
    output logic                  vid_gnt,
    output logic                  vid_rvalid,
    input  logic                  cpu_req,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic                  cpu_we,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_rvalid,
    input  logic                  dma_req,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic                  dma_we,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    output logic                  dma_gnt,
    output logic                  dma_rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_data_in,
    output logic                  sram_write_enable,
    input  logic [DATA_WIDTH-1:0] sram_data_out
`ifdef SRAM_ARB_STATS_EN
    ,
    input  logic                  stat_clear,
    output logic [STAT_WIDTH-1:0] stat_vid_grants,
    output logic [STAT_WIDTH-1:0] stat_cpu_grants,
    output logic [STAT_WIDTH-1:0] stat_dma_grants,
    output logic [STAT_WIDTH-1:0] stat_conflicts
`endif
);

    typedef enum logic [1:0] {
        SRC_VID = 2'd0,
        SRC_CPU = 2'd1,
        SRC_DMA = 2'd2
    } src_e;

    localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

    // Reject out-of-range configurations at elaboration time.
    if (MAX_WAIT < 1 || MAX_WAIT > 255 || STAT_WIDTH < 1) begin : g_param_check
        $error("sram_arbiter: MAX_WAIT must be 1..255 and STAT_WIDTH >= 1");
    end

    logic [7:0] cpu_wait_reg, dma_wait_reg;
    logic       rr_last_dma_reg;    // 1: DMA was the last CPU/DMA grant

    // In-flight tags: stage 1 during the SRAM access cycle, stage 2 while
    // sram_data_out is valid. The rvalid registers form the third slot.
    logic       t1_valid_reg, t1_read_reg, t2_valid_reg, t2_read_reg;
    src_e       t1_src_reg, t2_src_reg;

    logic                  cpu_starve, dma_starve, any_gnt;
    src_e                  gnt_src;
    logic [ADDR_WIDTH-1:0] gnt_addr;
    logic                  gnt_we;
    logic [DATA_WIDTH-1:0] gnt_wdata;

    assign cpu_starve = cpu_req && (cpu_wait_reg == WAIT_MAX);
    assign dma_starve = dma_req && (dma_wait_reg == WAIT_MAX);

    // Grant decision. Forced low during reset so nothing is accepted while
    // the pipeline is being cleared.
    always_comb begin
        vid_gnt = 1'b0;
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        if (!reset) begin
            if (cpu_starve && dma_starve) begin
                if (rr_last_dma_reg) cpu_gnt = 1'b1;
                else                 dma_gnt = 1'b1;
            end else if (cpu_starve) begin
                cpu_gnt = 1'b1;
            end else if (dma_starve) begin
                dma_gnt = 1'b1;
            end else if (vid_req) begin
                vid_gnt = 1'b1;
            end else if (cpu_req && dma_req) begin
                if (rr_last_dma_reg) cpu_gnt = 1'b1;
                else                 dma_gnt = 1'b1;
            end else if (cpu_req) begin
                cpu_gnt = 1'b1;
            end else if (dma_req) begin
                dma_gnt = 1'b1;
            end
        end
    end

    assign any_gnt = vid_gnt | cpu_gnt | dma_gnt;

    // Select the winning request's address/data for the SRAM registers.
    always_comb begin
        gnt_src   = SRC_VID;
        gnt_addr  = vid_addr;
        gnt_we    = 1'b0;
        gnt_wdata = '0;
        if (cpu_gnt) begin
            gnt_src   = SRC_CPU;
            gnt_addr  = cpu_addr;
            gnt_we    = cpu_we;
            gnt_wdata = cpu_wdata;
        end else if (dma_gnt) begin
            gnt_src   = SRC_DMA;
            gnt_addr  = dma_addr;
            gnt_we    = dma_we;
            gnt_wdata = dma_wdata;
        end
    end

    // Counter counts cycles spent waiting; a dropped request forgets its wait.
    function automatic logic [7:0] wait_next(input logic req, input logic gnt,
                                             input logic [7:0] cur);
        if (req && !gnt) return (cur == WAIT_MAX) ? cur : cur + 8'd1;
        return 8'd0;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_wait_reg      <= '0;
            dma_wait_reg      <= '0;
            rr_last_dma_reg   <= 1'b1;
            sram_addr         <= '0;
            sram_data_in      <= '0;
            sram_write_enable <= 1'b0;
            t1_valid_reg      <= 1'b0;
            t1_read_reg       <= 1'b0;
            t1_src_reg        <= SRC_VID;
            t2_valid_reg      <= 1'b0;
            t2_read_reg       <= 1'b0;
            t2_src_reg        <= SRC_VID;
            vid_rvalid        <= 1'b0;
            cpu_rvalid        <= 1'b0;
            dma_rvalid        <= 1'b0;
            rdata             <= '0;
        end else begin
            cpu_wait_reg <= wait_next(cpu_req, cpu_gnt, cpu_wait_reg);
            dma_wait_reg <= wait_next(dma_req, dma_gnt, dma_wait_reg);
            if (cpu_gnt)      rr_last_dma_reg <= 1'b0;
            else if (dma_gnt) rr_last_dma_reg <= 1'b1;

            // Address/data hold their last value on idle cycles.
            if (any_gnt) begin
                sram_addr    <= gnt_addr;
                sram_data_in <= gnt_wdata;
            end
            sram_write_enable <= any_gnt & gnt_we;

            t1_valid_reg <= any_gnt;
            t1_read_reg  <= ~gnt_we;
            t1_src_reg   <= gnt_src;
            t2_valid_reg <= t1_valid_reg;
            t2_read_reg  <= t1_read_reg;
            t2_src_reg   <= t1_src_reg;

            vid_rvalid <= t2_valid_reg && t2_read_reg && (t2_src_reg == SRC_VID);
            cpu_rvalid <= t2_valid_reg && t2_read_reg && (t2_src_reg == SRC_CPU);
            dma_rvalid <= t2_valid_reg && t2_read_reg && (t2_src_reg == SRC_DMA);
            if (t2_valid_reg && t2_read_reg) rdata <= sram_data_out;
        end
    end

`ifdef SRAM_ARB_STATS_EN
    logic conflict;
    assign conflict = (vid_req & cpu_req) | (vid_req & dma_req) | (cpu_req & dma_req);

    // Saturating event counters; a clear cycle discards its own events.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_vid_grants <= '0;
            stat_cpu_grants <= '0;
            stat_dma_grants <= '0;
            stat_conflicts  <= '0;
        end else if (stat_clear) begin
            stat_vid_grants <= '0;
            stat_cpu_grants <= '0;
            stat_dma_grants <= '0;
            stat_conflicts  <= '0;
        end else begin
            if (vid_gnt && stat_vid_grants != '1) stat_vid_grants <= stat_vid_grants + 1'b1;
            if (cpu_gnt && stat_cpu_grants != '1) stat_cpu_grants <= stat_cpu_grants + 1'b1;
            if (dma_gnt && stat_dma_grants != '1) stat_dma_grants <= stat_dma_grants + 1'b1;
            if (conflict && stat_conflicts != '1) stat_conflicts  <= stat_conflicts + 1'b1;
        end
    end
`endif

endmodule
